// File: rtl/multi_lock_manager_pkg.sv
// multi_lock_manager_pkg: shared opcodes, response codes and FSM state encoding
package multi_lock_manager_pkg;
  localparam logic [7:0] OP_LOCK   = 8'h04;
  localparam logic [7:0] OP_UNLOCK = 8'h06;
  localparam logic [7:0] RSP_NACK  = 8'h00;
  localparam logic [7:0] RSP_GRANT = 8'h01;
  typedef enum logic [1:0] {IDLE, RESP, GRANT} state_e;
endpackage

// File: rtl/multi_lock_manager_rr_arbiter.sv
// lock_rr_arbiter: first set request bit at or after base, wrapping around
module lock_rr_arbiter
  import multi_lock_manager_pkg::*;
#(
  parameter int MAX_ACCS = 16,
  localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic [MAX_ACCS-1:0] req,
  input  logic [ACC_BITS-1:0] base,
  output logic                found,
  output logic [ACC_BITS-1:0] idx
);
  int j;
  // Scan offsets from farthest to nearest so the nearest set bit is kept last
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = 0;
    for (int i = MAX_ACCS - 1; i >= 0; i--) begin
      j = int'(base) + i;
      if (j >= MAX_ACCS) j = j - MAX_ACCS;
      if (req[ACC_BITS'(j)]) begin
        found = 1'b1;
        idx = ACC_BITS'(j);
      end
    end
  end
endmodule

// File: rtl/multi_lock_manager.sv
// multi_lock_manager: multi-ID lock arbiter on the accelerator lock streams
module multi_lock_manager
  import multi_lock_manager_pkg::*;
#(
  parameter int MAX_ACCS = 16,
  parameter int NUM_LOCKS = 8,
  parameter int BLOCKING = 0,
  localparam int ACC_BITS = $clog2(MAX_ACCS),
  localparam int LOCK_BITS = $clog2(NUM_LOCKS)
) (
  input  logic                 aclk,
  input  logic                 ps_rst,
  input  logic                 lock_in_tvalid,
  output logic                 lock_in_tready,
  input  logic [ACC_BITS-1:0]  lock_in_tid,
  input  logic [63:0]          lock_in_tdata,
  output logic                 lock_out_tvalid,
  input  logic                 lock_out_tready,
  output logic [ACC_BITS-1:0]  lock_out_tdest,
  output logic [63:0]          lock_out_tdata,
  output logic                 lock_out_tlast,
  output logic [NUM_LOCKS-1:0] locked_mask,
  output logic                 lock_err
);
  state_e state_q, state_d;
  logic in_rdy_q, in_rdy_d, out_v_q, out_v_d, last_q, last_d, err_q, err_d;
  logic [ACC_BITS-1:0] dest_q, dest_d;
  logic [63:0] data_q, data_d;
  logic [NUM_LOCKS-1:0] held_q, held_d;
  logic [ACC_BITS-1:0] owner_q [NUM_LOCKS];
  logic [ACC_BITS-1:0] owner_d [NUM_LOCKS];
  logic [MAX_ACCS-1:0] waiters_q [NUM_LOCKS];
  logic [MAX_ACCS-1:0] waiters_d [NUM_LOCKS];
  logic [7:0] op, id, rsp;
  logic [LOCK_BITS-1:0] lid;
  logic id_ok, accept, is_owner, send, to_grant, arb_found, unused_bits;
  logic [ACC_BITS-1:0] dst, arb_base, arb_idx;
  logic [MAX_ACCS-1:0] arb_req;
  assign op = lock_in_tdata[7:0];
  assign id = lock_in_tdata[15:8];
  assign unused_bits = ^lock_in_tdata[63:16];
  assign lid = id[LOCK_BITS-1:0];
  assign id_ok = int'(id) < NUM_LOCKS;
  assign accept = lock_in_tvalid & in_rdy_q;
  assign is_owner = held_q[lid] && owner_q[lid] == lock_in_tid;
  assign arb_base = owner_q[lid] == ACC_BITS'(MAX_ACCS - 1) ? '0 : owner_q[lid] + 1'b1;
  assign arb_req = waiters_q[lid] & ~(MAX_ACCS'(1) << owner_q[lid]);
  lock_rr_arbiter #(.MAX_ACCS(MAX_ACCS)) u_arb (
    .req  (arb_req),
    .base (arb_base),
    .found(arb_found),
    .idx  (arb_idx)
  );
  // Decode the accepted beat, update the lock table and stage any response
  always_comb begin
    state_d = state_q;
    held_d = held_q;
    owner_d = owner_q;
    waiters_d = waiters_q;
    out_v_d = out_v_q;
    dest_d = dest_q;
    data_d = data_q;
    err_d = 1'b0;
    send = 1'b0;
    to_grant = 1'b0;
    rsp = RSP_NACK;
    dst = lock_in_tid;
    if (state_q != IDLE) begin
      if (lock_out_tready) begin
        state_d = IDLE;
        out_v_d = 1'b0;
      end
    end else if (accept) begin
      if (op == OP_LOCK) begin
        send = 1'b1;
        if (!id_ok) err_d = 1'b1;
        else if (!held_q[lid]) begin
          held_d[lid] = 1'b1;
          owner_d[lid] = lock_in_tid;
          rsp = RSP_GRANT;
        end else if (is_owner) rsp = RSP_GRANT;
        else if (BLOCKING != 0) begin
          send = 1'b0;
          waiters_d[lid][lock_in_tid] = 1'b1;
        end
      end else if (op == OP_UNLOCK) begin
        if (!id_ok || !is_owner) err_d = 1'b1;
        else if (arb_found) begin
          owner_d[lid] = arb_idx;
          waiters_d[lid][arb_idx] = 1'b0;
          send = 1'b1;
          to_grant = 1'b1;
          rsp = RSP_GRANT;
          dst = arb_idx;
        end else held_d[lid] = 1'b0;
      end else err_d = 1'b1;
    end
    if (send) begin
      state_d = to_grant ? GRANT : RESP;
      out_v_d = 1'b1;
      dest_d = dst;
      data_d = {48'b0, id, rsp};
    end
    in_rdy_d = state_d == IDLE;
    last_d = out_v_d;
  end
  // Register FSM state, lock table and all stream outputs
  always_ff @(posedge aclk or posedge ps_rst) begin
    if (ps_rst) begin
      state_q <= IDLE;
      in_rdy_q <= 1'b0;
      out_v_q <= 1'b0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      held_q <= '0;
      owner_q <= '{default: '0};
      waiters_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      in_rdy_q <= in_rdy_d;
      out_v_q <= out_v_d;
      last_q <= last_d;
      err_q <= err_d;
      dest_q <= dest_d;
      data_q <= data_d;
      held_q <= held_d;
      owner_q <= owner_d;
      waiters_q <= waiters_d;
    end
  end
  assign lock_in_tready = in_rdy_q;
  assign lock_out_tvalid = out_v_q;
  assign lock_out_tdest = dest_q;
  assign lock_out_tdata = data_q;
  assign lock_out_tlast = last_q;
  assign locked_mask = held_q;
  assign lock_err = err_q;
endmodule

// File: tb/tb_multi_lock_manager.sv
// tb_multi_lock_manager: directed and randomized checks of both lock modes
module tb_multi_lock_manager;
  typedef struct packed {
    logic v; logic [3:0] dest; logic [63:0] data; logic last; logic err; logic [7:0] mask; logic rdy;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_v [2], in_rdy [2], out_v [2], out_rdy [2], out_last [2], err [2];
  logic [3:0] in_tid [2], out_dest [2];
  logic [63:0] in_data [2], out_data [2];
  logic [7:0] mask [2];
  int checks = 0, errors = 0;
  bit mh [2][8];
  int mo [2][8];
  bit mw [2][8][16];
  always #5 clk = ~clk;
  multi_lock_manager #(.BLOCKING(0)) dut0 (
    .aclk(clk), .ps_rst(rst), .lock_in_tvalid(in_v[0]), .lock_in_tready(in_rdy[0]),
    .lock_in_tid(in_tid[0]), .lock_in_tdata(in_data[0]), .lock_out_tvalid(out_v[0]),
    .lock_out_tready(out_rdy[0]), .lock_out_tdest(out_dest[0]), .lock_out_tdata(out_data[0]),
    .lock_out_tlast(out_last[0]), .locked_mask(mask[0]), .lock_err(err[0]));
  multi_lock_manager #(.BLOCKING(1)) dut1 (
    .aclk(clk), .ps_rst(rst), .lock_in_tvalid(in_v[1]), .lock_in_tready(in_rdy[1]),
    .lock_in_tid(in_tid[1]), .lock_in_tdata(in_data[1]), .lock_out_tvalid(out_v[1]),
    .lock_out_tready(out_rdy[1]), .lock_out_tdest(out_dest[1]), .lock_out_tdata(out_data[1]),
    .lock_out_tlast(out_last[1]), .locked_mask(mask[1]), .lock_err(err[1]));

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 8; l++) begin
        mh[d][l] = 0;
        mo[d][l] = 0;
        for (int a = 0; a < 16; a++) mw[d][l][a] = 0;
      end
  endfunction

  // Lock semantics written from the rules: who holds, who waits, who is next.
  function automatic void model(input int d, input int tid, input int op, input int id, output obs_t e);
    int code, nxt, c;
    e = '0;
    code = -1;
    nxt = tid;
    if (op == 4) begin
      if (id >= 8) begin code = 0; e.err = 1; end
      else if (!mh[d][id]) begin mh[d][id] = 1; mo[d][id] = tid; code = 1; end
      else if (mo[d][id] == tid) code = 1;
      else if (d == 1) mw[d][id][tid] = 1;
      else code = 0;
    end else if (op == 6) begin
      if (id >= 8 || !mh[d][id] || mo[d][id] != tid) e.err = 1;
      else begin
        nxt = -1;
        for (int k = 1; k <= 16; k++) begin
          c = (mo[d][id] + k) % 16;
          if (nxt < 0 && mw[d][id][c] && c != mo[d][id]) nxt = c;
        end
        if (nxt >= 0) begin mo[d][id] = nxt; mw[d][id][nxt] = 0; code = 1; end
        else mh[d][id] = 0;
      end
    end else e.err = 1;
    if (code >= 0) begin
      e.v = 1;
      e.last = 1;
      e.dest = 4'(nxt);
      e.data = (64'(id) << 8) | 64'(code);
    end
    e.rdy = !e.v;
    for (int l = 0; l < 8; l++) e.mask[l] = mh[d][l];
  endfunction

  task automatic do_req(input int d, input int tid, input int op, input int id, output obs_t o, output obs_t e);
    int n = 0;
    logic [63:0] r;
    while (in_rdy[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin checks++; errors++; $display("FAIL ready_timeout dut%0d got 0 want 1", d); end
    model(d, tid, op, id, e);
    r = {$urandom(), $urandom()};
    r[15:0] = {8'(id), 8'(op)};
    in_v[d] = 1'b1;
    in_tid[d] = 4'(tid);
    in_data[d] = r;
    @(negedge clk);
    in_v[d] = 1'b0;
    o = {out_v[d], out_dest[d], out_data[d], out_last[d], err[d], mask[d], in_rdy[d]};
    if (o.v === 1'b1 && out_rdy[d] === 1'b1) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_v[d], out_dest[d], out_data[d], out_last[d], mask[d], err[d], in_rdy[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outs dut%0d got %h want 0", d, {out_v[d], out_dest[d], out_data[d], out_last[d], mask[d], err[d], in_rdy[d]});
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy[0] !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got %b want 0", in_rdy[0]); end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_rdy[d] !== 1'b1) begin errors++; $display("FAIL rdy_after_reset dut%0d got %b want 1", d, in_rdy[d]); end
    end
  endtask

  task automatic test_nonblocking();
    obs_t o, e;
    do_req(0, 3, 4, 2, o, e);
    checks++;
    if ({o.v, o.dest, o.data, o.last, o.mask} !== {1'b1, 4'd3, 64'h0201, 1'b1, 8'h04}) begin
      errors++; $display("FAIL nb_grant got %h want %h", {o.v, o.dest, o.data, o.last, o.mask}, {1'b1, 4'd3, 64'h0201, 1'b1, 8'h04});
    end
    do_req(0, 5, 4, 2, o, e);
    checks++;
    if ({o.v, o.dest, o.data, o.err} !== {1'b1, 4'd5, 64'h0200, 1'b0}) begin
      errors++; $display("FAIL nb_nack got %h want %h", {o.v, o.dest, o.data, o.err}, {1'b1, 4'd5, 64'h0200, 1'b0});
    end
    do_req(0, 3, 6, 2, o, e);
    checks++;
    if ({o.v, o.err, o.mask} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL nb_unlock got %h want %h", {o.v, o.err, o.mask}, {1'b0, 1'b0, 8'h00});
    end
  endtask

  task automatic test_blocking();
    obs_t o, e;
    do_req(1, 1, 4, 0, o, e);
    checks++;
    if ({o.v, o.dest, o.data} !== {1'b1, 4'd1, 64'h0001}) begin errors++; $display("FAIL blk_first got %h want %h", {o.v, o.dest, o.data}, {1'b1, 4'd1, 64'h0001}); end
    do_req(1, 9, 4, 0, o, e);
    checks++;
    if ({o.v, o.rdy} !== 2'b01) begin errors++; $display("FAIL blk_park9 got %b want 01", {o.v, o.rdy}); end
    do_req(1, 4, 4, 0, o, e);
    checks++;
    if ({o.v, o.rdy} !== 2'b01) begin errors++; $display("FAIL blk_park4 got %b want 01", {o.v, o.rdy}); end
    do_req(1, 1, 6, 0, o, e);
    checks++;
    if ({o.v, o.dest, o.data} !== {1'b1, 4'd4, 64'h0001}) begin errors++; $display("FAIL blk_to4 got %h want %h", {o.v, o.dest, o.data}, {1'b1, 4'd4, 64'h0001}); end
    do_req(1, 4, 6, 0, o, e);
    checks++;
    if ({o.v, o.dest, o.data} !== {1'b1, 4'd9, 64'h0001}) begin errors++; $display("FAIL blk_to9 got %h want %h", {o.v, o.dest, o.data}, {1'b1, 4'd9, 64'h0001}); end
    do_req(1, 9, 6, 0, o, e);
    checks++;
    if ({o.v, o.mask[0]} !== 2'b00) begin errors++; $display("FAIL blk_release got %b want 00", {o.v, o.mask[0]}); end
  endtask

  task automatic test_wrap();
    obs_t o, e;
    do_req(1, 15, 4, 3, o, e);
    do_req(1, 14, 4, 3, o, e);
    do_req(1, 0, 4, 3, o, e);
    do_req(1, 15, 6, 3, o, e);
    checks++;
    if ({o.v, o.dest, o.data} !== {1'b1, 4'd0, 64'h0301}) begin errors++; $display("FAIL wrap_to0 got %h want %h", {o.v, o.dest, o.data}, {1'b1, 4'd0, 64'h0301}); end
    do_req(1, 0, 6, 3, o, e);
    checks++;
    if ({o.v, o.dest} !== {1'b1, 4'd14}) begin errors++; $display("FAIL wrap_to14 got %h want %h", {o.v, o.dest}, {1'b1, 4'd14}); end
    do_req(1, 14, 6, 3, o, e);
  endtask

  task automatic test_errors();
    obs_t o, e;
    do_req(0, 2, 6, 1, o, e);
    checks++;
    if ({o.v, o.err} !== 2'b01) begin errors++; $display("FAIL err_unlock_free got %b want 01", {o.v, o.err}); end
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b want 0", err[0]); end
    do_req(0, 2, 4, 8, o, e);
    checks++;
    if ({o.v, o.err, o.dest, o.data} !== {1'b1, 1'b1, 4'd2, 64'h0800}) begin
      errors++; $display("FAIL err_bad_id got %h want %h", {o.v, o.err, o.dest, o.data}, {1'b1, 1'b1, 4'd2, 64'h0800});
    end
    do_req(0, 2, 7, 0, o, e);
    checks++;
    if ({o.v, o.err} !== 2'b01) begin errors++; $display("FAIL err_opcode got %b want 01", {o.v, o.err}); end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    time t0;
    do_req(1, 2, 4, 6, o, e);
    checks++;
    if ({o.v, o.rdy} !== 2'b10) begin errors++; $display("FAIL b2b_resp_rdy got %b want 10", {o.v, o.rdy}); end
    t0 = $time;
    for (int a = 3; a <= 5; a++) begin
      do_req(1, a, 4, 6, o, e);
      checks++;
      if ({o.v, o.rdy} !== 2'b01) begin errors++; $display("FAIL b2b_park acc%0d got %b want 01", a, {o.v, o.rdy}); end
    end
    checks++;
    if ($time - t0 != 30) begin errors++; $display("FAIL b2b_rate got %0t want 30", $time - t0); end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    int bad = 0;
    out_rdy[0] = 1'b0;
    do_req(0, 6, 4, 5, o, e);
    repeat (10) begin
      @(negedge clk);
      if ({out_v[0], out_dest[0], out_data[0], in_rdy[0]} !== {1'b1, 4'd6, 64'h0501, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles want 0", bad); end
    out_rdy[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_v[0], in_rdy[0]} !== 2'b01) begin errors++; $display("FAIL bp_release got %b want 01", {out_v[0], in_rdy[0]}); end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    do_req(1, 1, 4, 0, o, e);
    do_req(1, 2, 4, 0, o, e);
    do_req(1, 3, 4, 0, o, e);
    out_rdy[1] = 1'b0;
    do_req(1, 1, 6, 0, o, e);
    checks++;
    if ({o.v, o.dest} !== {1'b1, 4'd2}) begin errors++; $display("FAIL rm_pending got %h want %h", {o.v, o.dest}, {1'b1, 4'd2}); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_v[1], out_dest[1], out_data[1], out_last[1], mask[1], in_rdy[1]} !== '0) begin
      errors++; $display("FAIL rm_async got %h want 0", {out_v[1], out_dest[1], out_data[1], out_last[1], mask[1], in_rdy[1]});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_rdy[1] = 1'b1;
    do_req(1, 7, 4, 0, o, e);
    checks++;
    if ({o.v, o.dest, o.data, o.mask} !== {1'b1, 4'd7, 64'h0001, 8'h01}) begin
      errors++; $display("FAIL rm_after got %h want %h", {o.v, o.dest, o.data, o.mask}, {1'b1, 4'd7, 64'h0001, 8'h01});
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int tid, op, id, r;
    for (int d = 0; d < 2; d++)
      for (int it = 0; it < 300; it++) begin
        tid = $urandom_range(0, 15);
        id = ($urandom_range(0, 15) == 0) ? 8 + $urandom_range(0, 3) : $urandom_range(0, 2);
        r = $urandom_range(0, 9);
        op = r < 5 ? 4 : r < 9 ? 6 : $urandom_range(0, 255);
        if (op == 6 && id < 8 && mh[d][id] && $urandom_range(0, 3) != 0) tid = mo[d][id];
        out_rdy[d] = $urandom_range(0, 3) != 0;
        do_req(d, tid, op, id, o, e);
        checks++;
        if ({o.v, o.err, o.mask, o.rdy} !== {e.v, e.err, e.mask, e.rdy}) begin
          errors++; $display("FAIL rnd_ctrl dut%0d it%0d got %h want %h", d, it, {o.v, o.err, o.mask, o.rdy}, {e.v, e.err, e.mask, e.rdy});
        end
        if (e.v) begin
          checks++;
          if ({o.dest, o.data, o.last} !== {e.dest, e.data, e.last}) begin
            errors++; $display("FAIL rnd_resp dut%0d it%0d got %h want %h", d, it, {o.dest, o.data, o.last}, {e.dest, e.data, e.last});
          end
        end
        if (o.v === 1'b1 && !out_rdy[d]) begin
          repeat (2) @(negedge clk);
          checks++;
          if ({out_v[d], out_data[d]} !== {1'b1, e.data}) begin
            errors++; $display("FAIL rnd_hold dut%0d it%0d got %h want %h", d, it, {out_v[d], out_data[d]}, {1'b1, e.data});
          end
          out_rdy[d] = 1'b1;
          @(negedge clk);
        end
      end
    out_rdy[0] = 1'b1;
    out_rdy[1] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_v[d] = 1'b0;
      in_tid[d] = '0;
      in_data[d] = '0;
      out_rdy[d] = 1'b1;
    end
    model_reset();
    test_reset();
    test_nonblocking();
    test_blocking();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
